cache_bus_arbiter: RTL

- Common-bus arbiter for the 8-core MESI cache system; directly downstream of the per-core cache request signals (Com_Bus_Req_proc_*, Com_Bus_Req_snoop_*, Mem_snoop_req); produces the grants consumed by the caches and lower-level memory.
- Two-level ownership:
  - Round-robin bus ownership among the 8 processor-side caches.
  - While a processor owns the bus, a nested snoop-response grant goes to one snooping cache, or to memory when no cache responds.
- Includes a hold-time watchdog.

---
 rtl/cache_bus_arbiter_if.sv | 28 ++
 rtl/cache_bus_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter_if.sv
// Request/grant bundle between the 8-core MESI caches, memory and the common-bus arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface cache_bus_arbiter_if #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4
);
    logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
    logic                 Mem_snoop_req;
    logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop_vec;
    logic                 Com_Bus_Gnt_snoop;
    logic                 Mem_snoop_gnt;
    logic                 Arb_timeout;
    logic [1:0]           Arb_state;

    modport master (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop_vec, Com_Bus_Gnt_snoop,
               Mem_snoop_gnt, Arb_timeout, Arb_state
    );

    modport slave (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop_vec, Com_Bus_Gnt_snoop,
               Mem_snoop_gnt, Arb_timeout, Arb_state
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Common-bus arbiter: round-robin processor ownership with a nested snoop/memory
// data-response grant, registered outputs and a sticky hold-time watchdog.
module cache_bus_arbiter #(
    parameter int NUM_PROC   = 8,
    parameter int NUM_SNOOP  = 4,
    parameter int MAX_HOLD   = 1024,
    parameter int HOLD_CNT_W = 11
) (
    input logic               clk,
    input logic               rst_n,
    cache_bus_arbiter_if.slave bus_if
);
    localparam int PW = (NUM_PROC  > 1) ? $clog2(NUM_PROC)  : 1;
    localparam int SW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_SNOOP = 2'd2,
        ST_MEM   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_PROC-1:0]   gnt_proc_q, gnt_proc_d;
    logic [NUM_SNOOP-1:0]  gnt_snoop_q, gnt_snoop_d;
    logic                  mem_gnt_q, mem_gnt_d;
    logic                  timeout_q, timeout_d;
    logic [PW-1:0]         proc_ptr_q, proc_ptr_d;
    logic [SW-1:0]         snoop_ptr_q, snoop_ptr_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;

    logic                  proc_found, snoop_found;
    logic [PW-1:0]         proc_idx;
    logic [SW-1:0]         snoop_idx;
    logic                  owner_req, snoop_req_held;

    // Rotating priority search starting at each pointer.
    always_comb begin
        proc_found  = 1'b0;
        proc_idx    = '0;
        snoop_found = 1'b0;
        snoop_idx   = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (!proc_found && bus_if.Com_Bus_Req_proc[(int'(proc_ptr_q) + i) % NUM_PROC]) begin
                proc_found = 1'b1;
                proc_idx   = PW'((int'(proc_ptr_q) + i) % NUM_PROC);
            end
        end
        for (int j = 0; j < NUM_SNOOP; j++) begin
            if (!snoop_found && bus_if.Com_Bus_Req_snoop[(int'(snoop_ptr_q) + j) % NUM_SNOOP]) begin
                snoop_found = 1'b1;
                snoop_idx   = SW'((int'(snoop_ptr_q) + j) % NUM_SNOOP);
            end
        end
    end

    assign owner_req      = |(bus_if.Com_Bus_Req_proc & gnt_proc_q);
    assign snoop_req_held = |(bus_if.Com_Bus_Req_snoop & gnt_snoop_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        mem_gnt_d   = mem_gnt_q;
        proc_ptr_d  = proc_ptr_q;
        snoop_ptr_d = snoop_ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                mem_gnt_d   = 1'b0;
                if (proc_found) begin
                    gnt_proc_d = NUM_PROC'(1) << proc_idx;
                    proc_ptr_d = PW'((int'(proc_idx) + 1) % NUM_PROC);
                    state_d    = ST_PROC;
                end
            end
            ST_PROC: begin
                if (!owner_req) begin
                    gnt_proc_d = '0;
                    state_d    = ST_IDLE;
                end else if (snoop_found) begin
                    gnt_snoop_d = NUM_SNOOP'(1) << snoop_idx;
                    snoop_ptr_d = SW'((int'(snoop_idx) + 1) % NUM_SNOOP);
                    state_d     = ST_SNOOP;
                end else if (bus_if.Mem_snoop_req) begin
                    mem_gnt_d = 1'b1;
                    state_d   = ST_MEM;
                end
            end
            ST_SNOOP: begin
                if (!owner_req) begin
                    gnt_proc_d  = '0;
                    gnt_snoop_d = '0;
                    state_d     = ST_IDLE;
                end else if (!snoop_req_held) begin
                    gnt_snoop_d = '0;
                    state_d     = ST_PROC;
                end
            end
            ST_MEM: begin
                if (!owner_req) begin
                    gnt_proc_d = '0;
                    mem_gnt_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if (!bus_if.Mem_snoop_req) begin
                    mem_gnt_d = 1'b0;
                    state_d   = ST_PROC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold count restarts at each fresh grant and saturates; the watchdog flag is sticky.
    always_comb begin
        hold_d = '0;
        if (state_q != ST_IDLE) begin
            hold_d = (hold_q == HOLD_CNT_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        end
        timeout_d = timeout_q | (hold_d == HOLD_CNT_W'(MAX_HOLD));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            timeout_q   <= 1'b0;
            proc_ptr_q  <= '0;
            snoop_ptr_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            mem_gnt_q   <= mem_gnt_d;
            timeout_q   <= timeout_d;
            proc_ptr_q  <= proc_ptr_d;
            snoop_ptr_q <= snoop_ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus_if.Com_Bus_Gnt_proc      = gnt_proc_q;
    assign bus_if.Com_Bus_Gnt_snoop_vec = gnt_snoop_q;
    assign bus_if.Com_Bus_Gnt_snoop     = |gnt_snoop_q;
    assign bus_if.Mem_snoop_gnt         = mem_gnt_q;
    assign bus_if.Arb_timeout           = timeout_q;
    assign bus_if.Arb_state             = state_q;
endmodule
